// File: rtl/mem_req_queue.sv
// mem_req_queue: upstream request stage for memory_controller.
// Client requests are buffered in a small FIFO. Each one is issued to the
// controller as a single-cycle read/write enable. The command is then held
// stable until the controller has gone busy and returned to ready. Read data
// comes back on a one-cycle response strobe. A BUSY-cycle watchdog raises a
// sticky error if the controller never completes.
module mem_req_queue #(
    parameter int AW      = 8,   // address width, matches controller addr
    parameter int DW      = 8,   // data width, matches controller data_in/data_out
    parameter int DEPTH   = 4,   // request FIFO entries, power of two, >= 2
    parameter int TIMEOUT = 64   // BUSY cycles allowed before timeout_err
) (
    input  logic                     clk,
    input  logic                     reset,

    // client request channel
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [AW-1:0]            req_addr,
    input  logic [DW-1:0]            req_wdata,

    // client completion channel
    output logic                     rsp_valid,
    output logic [AW-1:0]            rsp_addr,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     wr_done,

    // memory_controller command interface
    output logic                     mc_read_en,
    output logic                     mc_write_en,
    output logic [AW-1:0]            mc_addr,
    output logic [DW-1:0]            mc_data_in,
    input  logic [DW-1:0]            mc_data_out,
    input  logic                     mc_ready,

    // status
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     timeout_err
);

    localparam int PW = $clog2(DEPTH);       // pointer width
    localparam int CW = PW + 1;              // count width, holds 0..DEPTH
    localparam int TW = $clog2(TIMEOUT + 1); // watchdog width

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] WDOG_LAST  = TW'(TIMEOUT - 1);

    // command sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    entry_t          head;

    logic [1:0]      state;
    logic            cmd_write;  // op of the command currently held on mc_*
    logic            low_seen;   // controller has dropped mc_ready since the issue
    logic [TW-1:0]   wdog;       // BUSY cycles elapsed for the current command

    logic            push;
    logic            pop;

    // A full FIFO refuses new requests even in a cycle that also dequeues,
    // because req_ready comes only from the registered count.
    assign req_ready  = (count < FULL_COUNT);
    assign push       = req_valid && req_ready;
    assign pop        = (state == ST_IDLE) && (count != '0) && mc_ready;
    assign head       = fifo_mem[rd_ptr];
    assign fifo_count = count;

    // Request storage. Only entries below count are ever read.
    // NOTE: the storage array has no reset, because an entry is always written before it is read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: req_write, addr: req_addr, data: req_wdata};
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses non-blocking assignment, so all of them update together at the edge.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Command sequencer: pop, issue once, wait out the controller, then report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd_write   <= 1'b0;
            mc_addr     <= '0;
            mc_data_in  <= '0;
            low_seen    <= 1'b0;
            wdog        <= '0;
            timeout_err <= 1'b0;
            rsp_addr    <= '0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state      <= ST_ISSUE;
                        cmd_write  <= head.write;
                        mc_addr    <= head.addr;
                        mc_data_in <= head.data;
                    end
                end

                ST_ISSUE: begin
                    state    <= ST_BUSY;
                    low_seen <= 1'b0;
                    wdog     <= '0;
                end

                ST_BUSY: begin
                    if (mc_ready && low_seen) begin
                        // mc_ready is already high, so mc_data_out holds the read result.
                        state <= ST_DONE;
                        if (!cmd_write) begin
                            rsp_addr  <= mc_addr;
                            rsp_rdata <= mc_data_out;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        // The controller never finished. Drop the command without a response.
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= wdog + TW'(1);
                        if (!mc_ready) begin
                            low_seen <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Enables and completion strobes are decoded from the one-cycle ISSUE and DONE states.
    always_comb begin
        // NOTE: defaults come first so that every path assigns every output and no latch is inferred.
        mc_read_en  = 1'b0;
        mc_write_en = 1'b0;
        rsp_valid   = 1'b0;
        wr_done     = 1'b0;
        case (state)
            ST_ISSUE: begin
                mc_read_en  = !cmd_write;
                mc_write_en = cmd_write;
            end
            ST_DONE: begin
                rsp_valid = !cmd_write;
                wr_done   = cmd_write;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_req_queue.sv
// Testbench for mem_req_queue. The behavioural controller model stands in for
// memory_controller. A request-level reference model predicts what the DUT
// must issue and what it must return. It keeps an in-order queue of accepted
// requests and a shadow memory that is updated as writes complete.
module tb_mem_req_queue;

    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_rdata;
    logic          wr_done;
    logic          mc_read_en;
    logic          mc_write_en;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data_in;
    logic [DW-1:0] mc_data_out = '0;
    logic          mc_ready = 1'b1;
    logic [2:0]    fifo_count;
    logic          timeout_err;

    always #5 clk = ~clk;

    mem_req_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_addr    (rsp_addr),
        .rsp_rdata   (rsp_rdata),
        .wr_done     (wr_done),
        .mc_read_en  (mc_read_en),
        .mc_write_en (mc_write_en),
        .mc_addr     (mc_addr),
        .mc_data_in  (mc_data_in),
        .mc_data_out (mc_data_out),
        .mc_ready    (mc_ready),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    req_t          iss_q[$];   // accepted, not yet issued, in FIFO order
    req_t          cmp_q[$];   // issued, awaiting completion
    logic [DW-1:0] ref_mem [256] = '{default: 8'h00};
    logic [DW-1:0] rsp_log[$];
    int            wr_cnt = 0;
    int            rsp_cnt = 0;

    // controller model knobs and state
    logic          ctl_stall = 1'b0;  // hold mc_ready low while idle
    logic          ctl_hang  = 1'b0;  // never finish the current operation
    int            ctl_busy  = 1;     // busy cycles per operation
    int            busy_left = 0;
    logic          pending   = 1'b0;
    logic [DW-1:0] rd_latch  = '0;
    logic [DW-1:0] ctl_mem [256] = '{default: 8'h00};

    // monitor state
    logic          prev_en = 1'b0;
    logic          prev_to = 1'b0;
    logic          hold_active = 1'b0;
    logic [AW-1:0] held_addr = '0;
    logic [DW-1:0] held_data = '0;

    // Behavioural memory controller: drops ready after sampling an enable,
    // stays busy for ctl_busy cycles, then presents read data with ready high.
    always @(posedge clk) begin
        if (mc_write_en) begin
            ctl_mem[mc_addr] <= mc_data_in;
        end
        if (mc_read_en || mc_write_en) begin
            rd_latch  <= ctl_mem[mc_addr];
            mc_ready  <= 1'b0;
            busy_left <= ctl_busy;
            pending   <= 1'b1;
        end else if (pending) begin
            if (!ctl_hang) begin
                if (busy_left > 1) begin
                    busy_left <= busy_left - 1;
                end else begin
                    mc_ready    <= 1'b1;
                    mc_data_out <= rd_latch;
                    pending     <= 1'b0;
                end
            end
        end else begin
            mc_ready <= !ctl_stall;
        end
    end

    // Scoreboard: compares every issue and completion against the reference model.
    always @(negedge clk) begin
        req_t e;
        logic en;
        if (reset) begin
            hold_active = 1'b0;
            prev_en     = 1'b0;
            prev_to     = 1'b0;
        end else begin
            en = mc_read_en | mc_write_en;
            if (en) begin
                checks++;
                if (mc_read_en && mc_write_en) begin
                    errors++;
                    $display("FAIL enable_exclusive: read_en=%b write_en=%b, required only one high", mc_read_en, mc_write_en);
                end
                checks++;
                if (prev_en) begin
                    errors++;
                    $display("FAIL enable_width: enable high on two consecutive cycles, required a one-cycle pulse");
                end
                checks++;
                if (iss_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_issue: enable with addr=%h, required no issue (nothing queued)", mc_addr);
                end else begin
                    e = iss_q.pop_front();
                    if (mc_write_en !== e.write || mc_addr !== e.addr || (e.write && mc_data_in !== e.data)) begin
                        errors++;
                        $display("FAIL issue_cmd: got write=%b addr=%h data=%h, required write=%b addr=%h data=%h",
                                 mc_write_en, mc_addr, mc_data_in, e.write, e.addr, e.data);
                    end
                    cmp_q.push_back(e);
                end
                hold_active = 1'b1;
                held_addr   = mc_addr;
                held_data   = mc_data_in;
            end else if (hold_active) begin
                checks++;
                if (mc_addr !== held_addr || mc_data_in !== held_data) begin
                    errors++;
                    $display("FAIL cmd_hold: addr=%h data=%h, required stable addr=%h data=%h", mc_addr, mc_data_in, held_addr, held_data);
                end
            end

            if (rsp_valid || wr_done) begin
                checks++;
                if (rsp_valid && wr_done) begin
                    errors++;
                    $display("FAIL strobe_exclusive: rsp_valid=1 wr_done=1, required at most one");
                end
            end

            if (wr_done) begin
                wr_cnt++;
                checks++;
                if (cmp_q.size() == 0 || !cmp_q[0].write) begin
                    errors++;
                    $display("FAIL wr_done_order: wr_done with %0d outstanding, required a write at the head", cmp_q.size());
                end else begin
                    e = cmp_q.pop_front();
                    ref_mem[e.addr] = e.data;
                end
            end

            if (rsp_valid) begin
                rsp_cnt++;
                rsp_log.push_back(rsp_rdata);
                checks++;
                if (cmp_q.size() == 0 || cmp_q[0].write) begin
                    errors++;
                    $display("FAIL rsp_order: rsp_valid with %0d outstanding, required a read at the head", cmp_q.size());
                end else begin
                    e = cmp_q.pop_front();
                    checks++;
                    if (rsp_addr !== e.addr || rsp_rdata !== ref_mem[e.addr]) begin
                        errors++;
                        $display("FAIL rsp_data: got addr=%h data=%h, required addr=%h data=%h",
                                 rsp_addr, rsp_rdata, e.addr, ref_mem[e.addr]);
                    end
                end
            end

            if (wr_done || rsp_valid || (timeout_err && !prev_to)) begin
                hold_active = 1'b0;
            end
            prev_en = en;
            prev_to = timeout_err;
        end
    end

    // Present one request and hold it until the DUT accepts it. Called at a negedge.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n = 0;
        req_t e;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL send_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end else begin
            e.write = w;
            e.addr  = a;
            e.data  = d;
            iss_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait for every accepted request to complete, within a cycle budget.
    task automatic wait_drain(input string name);
        int n = 0;
        while ((iss_q.size() != 0 || cmp_q.size() != 0 || fifo_count != 3'd0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (iss_q.size() != 0 || cmp_q.size() != 0 || fifo_count != 3'd0) begin
            errors++;
            $display("FAIL %s_drain: unissued=%0d outstanding=%0d fifo_count=%0d, required all 0",
                     name, iss_q.size(), cmp_q.size(), fifo_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mc_read_en, mc_write_en, rsp_valid, wr_done, timeout_err, fifo_count} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: en=%b%b rsp=%b wr=%b to=%b count=%0d, required all 0",
                     mc_read_en, mc_write_en, rsp_valid, wr_done, timeout_err, fifo_count);
        end
        checks++;
        if ({mc_addr, mc_data_in, rsp_addr, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: mc_addr=%h mc_data_in=%h rsp_addr=%h rsp_rdata=%h, required 0",
                     mc_addr, mc_data_in, rsp_addr, rsp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        int n;
        int wr0 = wr_cnt;
        ctl_busy = 1;
        send(1'b1, 8'h01, 8'h16);
        n = 1;
        while (!wr_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL write_latency: wr_done %0d cycles after accept, required 5", n);
        end
        wait_drain("write_basic");
        checks++;
        if (wr_cnt - wr0 != 1) begin
            errors++;
            $display("FAIL write_basic_count: wr_done pulses=%0d, required 1", wr_cnt - wr0);
        end
    endtask

    task automatic test_write_read();
        int wr0 = wr_cnt;
        int rs0 = rsp_cnt;
        send(1'b1, 8'h02, 8'hAA);
        send(1'b0, 8'h02, 8'h00);
        wait_drain("write_read");
        checks++;
        if (wr_cnt - wr0 != 1 || rsp_cnt - rs0 != 1) begin
            errors++;
            $display("FAIL write_read_count: wr_done=%0d rsp_valid=%0d, required 1 and 1", wr_cnt - wr0, rsp_cnt - rs0);
        end
        checks++;
        if (rsp_log.size() == 0 || rsp_log[$] !== 8'hAA || rsp_addr !== 8'h02) begin
            errors++;
            $display("FAIL write_read_data: rsp_addr=%h rsp_rdata=%h, required 02 and aa", rsp_addr, rsp_rdata);
        end
    endtask

    task automatic test_interleaved();
        int            rs0;
        logic [DW-1:0] expect_v [4];
        ctl_busy = 2;
        expect_v[0] = 8'h16;
        expect_v[1] = 8'hAA;
        expect_v[2] = 8'h16;
        expect_v[3] = 8'hAA;
        send(1'b1, 8'h01, 8'h16);
        send(1'b1, 8'h02, 8'hAA);
        rs0 = rsp_cnt;
        rsp_log.delete();
        for (int i = 0; i < 4; i++) begin
            send(1'b0, (i % 2 == 0) ? 8'h01 : 8'h02, 8'($urandom));
        end
        wait_drain("interleaved");
        checks++;
        if (rsp_cnt - rs0 != 4 || rsp_log.size() != 4) begin
            errors++;
            $display("FAIL interleaved_count: responses=%0d, required 4", rsp_cnt - rs0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rsp_log[i] !== expect_v[i]) begin
                    errors++;
                    $display("FAIL interleaved_data[%0d]: rsp_rdata=%h, required %h", i, rsp_log[i], expect_v[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        int   n;
        int   done0 = wr_cnt + rsp_cnt;
        int   model_count = 0;
        req_t e;
        ctl_stall = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            send(1'($urandom), 8'($urandom_range(8, 15)), 8'($urandom));
            model_count++;
            checks++;
            if (int'(fifo_count) != model_count) begin
                errors++;
                $display("FAIL full_count[%0d]: fifo_count=%0d, required %0d", i, fifo_count, model_count);
            end
        end
        // fifth request must wait while the controller stalls
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'($urandom_range(8, 15));
        req_wdata = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_ready !== 1'b0 || int'(fifo_count) != DEPTH) begin
                errors++;
                $display("FAIL full_block[%0d]: req_ready=%b fifo_count=%0d, required 0 and %0d", i, req_ready, fifo_count, DEPTH);
            end
            @(negedge clk);
        end
        ctl_stall = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL full_release: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end else begin
            e.write = req_write;
            e.addr  = req_addr;
            e.data  = req_wdata;
            iss_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (int'(fifo_count) != DEPTH) begin
            errors++;
            $display("FAIL full_refill: fifo_count=%0d, required %0d", fifo_count, DEPTH);
        end
        wait_drain("full");
        checks++;
        if (wr_cnt + rsp_cnt - done0 != DEPTH + 1) begin
            errors++;
            $display("FAIL full_completions: completions=%0d, required %0d", wr_cnt + rsp_cnt - done0, DEPTH + 1);
        end
    endtask

    task automatic test_timeout();
        int n;
        int cyc;
        int rs0 = rsp_cnt;
        int wr0 = wr_cnt;
        ctl_busy = 1;
        ctl_hang = 1'b1;
        send(1'b0, 8'h01, 8'h00);
        n = 0;
        while (!mc_read_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!mc_read_en) begin
            errors++;
            $display("FAIL timeout_issue: mc_read_en=%b, required 1", mc_read_en);
        end
        send(1'b1, 8'($urandom_range(8, 15)), 8'($urandom));
        cyc = 1;
        while (!timeout_err && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_cycles: timeout_err after %0d cycles from issue, required %0d", cyc, TIMEOUT + 1);
        end
        checks++;
        if (rsp_cnt != rs0) begin
            errors++;
            $display("FAIL timeout_no_rsp: responses=%0d, required 0", rsp_cnt - rs0);
        end
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL timeout_queued: fifo_count=%0d, required 1", fifo_count);
        end
        if (cmp_q.size() != 0) begin
            void'(cmp_q.pop_front());
        end
        ctl_hang = 1'b0;
        wait_drain("timeout");
        checks++;
        if (wr_cnt - wr0 != 1 || rsp_cnt != rs0) begin
            errors++;
            $display("FAIL timeout_next: wr_done=%0d rsp_valid=%0d, required 1 and 0", wr_cnt - wr0, rsp_cnt - rs0);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        ctl_busy = 6;
        send(1'b0, 8'($urandom_range(0, 7)), 8'h00);
        send(1'b1, 8'($urandom_range(0, 7)), 8'($urandom));
        send(1'b1, 8'($urandom_range(0, 7)), 8'($urandom));
        n = 0;
        while (mc_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fifo_count !== 3'd2 || mc_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_setup: fifo_count=%0d mc_ready=%b, required 2 and 0", fifo_count, mc_ready);
        end
        reset = 1'b1;
        iss_q.delete();
        cmp_q.delete();
        @(negedge clk);
        checks++;
        if ({mc_read_en, mc_write_en, rsp_valid, wr_done, timeout_err, fifo_count,
             mc_addr, mc_data_in, rsp_addr, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: en=%b%b rsp=%b wr=%b to=%b count=%0d mc_addr=%h, required all 0",
                     mc_read_en, mc_write_en, rsp_valid, wr_done, timeout_err, fifo_count, mc_addr);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: req_ready=%b, required 1", req_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (mc_read_en || mc_write_en || rsp_valid || wr_done || fifo_count != 3'd0) begin
                errors++;
                $display("FAIL reset_mid_quiet[%0d]: en=%b%b rsp=%b wr=%b count=%0d, required all 0",
                         i, mc_read_en, mc_write_en, rsp_valid, wr_done, fifo_count);
            end
        end
    endtask

    task automatic test_random();
        int done0 = wr_cnt + rsp_cnt;
        for (int i = 0; i < 40; i++) begin
            ctl_busy = int'($urandom_range(1, 3));
            send(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain("random");
        checks++;
        if (wr_cnt + rsp_cnt - done0 != 40) begin
            errors++;
            $display("FAIL random_completions: completions=%0d, required 40", wr_cnt + rsp_cnt - done0);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_read();
        test_interleaved();
        test_full();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a bounded wait is itself broken.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at 2 ms, required completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mem_req_queue.md
Name: mem_req_queue

Overview:
- Upstream request stage for memory_controller.
- Accepts read/write requests from a client over a valid/ready handshake and buffers them in a FIFO.
- Issues each request to the controller as a single-cycle read_en/write_en pulse with stable addr/data_in, then waits for the controller's ready before issuing the next.
- Read results are captured from data_out and returned with a one-cycle response strobe; a watchdog flags a controller that never completes.

Parameters:
AW, 8, address width (matches controller addr)
DW, 8, data width (matches controller data_in/data_out)
DEPTH, 4, request FIFO entries (power of two, >=2)
TIMEOUT, 64, max cycles in BUSY before timeout_err

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
req_valid  in  1  client request valid
req_ready  out  1  FIFO can accept (not full)
req_write  in  1  1=write, 0=read
req_addr  in  AW  request address
req_wdata  in  DW  write data (ignored for reads)
rsp_valid  out  1  one-cycle strobe: read data returned
rsp_addr  out  AW  address of returned read
rsp_rdata  out  DW  returned read data
wr_done  out  1  one-cycle strobe: write completed
mc_read_en  out  1  to controller read_en
mc_write_en  out  1  to controller write_en
mc_addr  out  AW  to controller addr
mc_data_in  out  DW  to controller data_in
mc_data_out  in  DW  from controller data_out
mc_ready  in  1  from controller ready (high = idle/done)
fifo_count  out  clog2(DEPTH)+1  entries held
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (sync, active-high, clk edge): FIFO emptied (count=0, pointers 0); FSM=IDLE; all outputs 0 except req_ready=1. Reset mid-transaction aborts it; no rsp_valid/wr_done for the aborted request; queued entries discarded.
- Enqueue: on clk when req_valid&&req_ready; entry {write,addr,wdata} stored. req_ready = (count<DEPTH), combinational from registered count.
- Simultaneous enqueue+dequeue when full: enqueue refused (req_ready=0 that cycle); dequeue proceeds.
- Pointers wrap modulo DEPTH.
- Controller contract: it deasserts mc_ready in the cycle after sampling an enable and reasserts it when the operation is complete (busy >=1 cycle); data_out is valid while mc_ready is high after a read.
- FSM:
  - IDLE: if count>0 and mc_ready=1 -> ISSUE; pop head into command register (mc_addr, mc_data_in, op).
  - ISSUE (1 cycle): mc_read_en or mc_write_en=1 per op, exactly one cycle -> BUSY. mc_addr/mc_data_in held stable from ISSUE until DONE.
  - BUSY: enable low; wait for mc_ready 0 then 1 (low-seen flag); on mc_ready=1 with low-seen -> DONE. Watchdog counts BUSY cycles; at TIMEOUT -> timeout_err=1 (sticky until reset), FSM -> IDLE, no response emitted.
  - DONE (1 cycle): read: rsp_valid=1, rsp_rdata=mc_data_out sampled, rsp_addr=mc_addr. Write: wr_done=1. -> IDLE.
- Minimum per-request latency dequeue to response: IDLE->ISSUE->BUSY(>=2)->DONE = 5 cycles with a 1-cycle-busy controller; back-to-back issue never overlaps.
- rsp_valid/wr_done never both high; rsp_rdata/rsp_addr hold last value otherwise.
- Requests complete strictly in FIFO order.
- Empty: FSM stays IDLE, enables low. mc_ready=0 while IDLE blocks issue.

Test Plan:
- Reset 3 cycles, enqueue write addr=1 data=0x16 -> one-cycle mc_write_en with mc_addr=1, mc_data_in=0x16; wr_done pulses once after mc_ready returns; fifo_count returns 0.
- Write addr=2 data=0xAA, then read addr=2 (model returns stored value) -> rsp_valid once, rsp_addr=2, rsp_rdata=0xAA; ordering write-before-read preserved.
- Enqueue DEPTH+1 requests back-to-back with controller stalled (mc_ready held 0) -> req_ready drops after 4, fifo_count=4, 5th accepted only after first dequeue.
- Read addr=1, controller never reasserts mc_ready -> timeout_err=1 after TIMEOUT BUSY cycles, no rsp_valid, next queued request then issues.
- Assert reset during BUSY with 2 entries queued -> next cycle all outputs 0, req_ready=1, fifo_count=0, no stray enables or responses.
- Interleaved reads of addr 1 and 2 after writes 0x16/0xAA -> responses 0x16 then 0xAA in order, each enable exactly one cycle wide.
